fifo_rd_stream_adapter: RTL and testbench
=========================================

Name: fifo_rd_stream_adapter

Overview:
Read-side drain stage placed directly downstream of the async FIFO, in the read clock domain. It converts the FIFO's rd_en/rdata/empty interface, which has one-cycle registered read latency, into a valid/ready stream with full throughput and no bubbles. A 2-entry output buffer absorbs the read latency and consumer backpressure. It also provides a synchronous flush and a transfer counter.

Parameters:
WIDTH, 8, data width; must match the FIFO WIDTH.
CNT_WIDTH, 16, width of the transfer counter.

Ports:
clk_i  input  1  read-domain clock; the same net as the FIFO rd_clk_i.
rst_i  input  1  asynchronous reset, active-high.
fifo_empty_i  input  1  FIFO empty flag.
fifo_rdata_i  input  WIDTH  FIFO read data; valid in the cycle after rd_en_o is sampled high.
fifo_rd_error_i  input  1  FIFO read-error flag.
rd_en_o  output  1  read request to the FIFO.
m_valid_o  output  1  stream valid.
m_data_o  output  WIDTH  stream data.
m_ready_i  input  1  stream ready from the consumer.
flush_i  input  1  synchronous discard of buffered and in-flight data.
words_out_o  output  CNT_WIDTH  count of completed stream transfers.
protocol_err_o  output  1  sticky error flag.

Behaviour:
Reset (asynchronous, active-high):
- Registers: buffer occupancy occ=0, inflight=0, both buffer entries=0, words_out_o=0, protocol_err_o=0.
- Outputs: m_valid_o=0, m_data_o=0, rd_en_o=0 for as long as rst_i is high.

Buffer:
- 2-entry FIFO-ordered register buffer, head and tail entries.
- occ takes values 0, 1 or 2. State names: EMPTY, ONE, TWO.
- m_valid_o = (occ != 0); m_data_o = head entry. Both are register outputs.

Transfer rules:
- pop = m_valid_o & m_ready_i.
- m_data_o holds stable while m_valid_o=1 and m_ready_i=0.

Read issue (combinational):
- rd_en_o = !rst_i & !flush_i & !fifo_empty_i & ((occ + inflight - pop) < 2).
- There is a deliberate combinational path m_ready_i -> rd_en_o.
- rd_en_o is never asserted while fifo_empty_i=1.

In-flight tracking:
- inflight <= rd_en_o on every edge.
- When inflight=1, fifo_rdata_i is captured at the end of that cycle.
- The captured word is written into the buffer slot after any pop, so order is preserved.

Latency and throughput:
- rd_en_o high in cycle t -> data in the buffer and m_valid_o=1 in cycle t+2.
- Steady state with m_ready_i held 1 and the FIFO non-empty: occ=1, inflight=1, one word per clock.

State transitions (push = inflight):
- EMPTY: push -> ONE.
- ONE: push & !pop -> TWO; pop & !push -> EMPTY; push & pop -> ONE (head replaced).
- TWO: pop -> ONE, with the tail moving to the head. push cannot occur in TWO because the issue rule forbids it.
- Invariant: occ + inflight <= 2 at all times. A violation is an implementation bug and the bench asserts on it.

Flush:
- In a cycle with flush_i=1, a transfer with pop=1 still completes and is counted.
- rd_en_o=0 during that cycle.
- Next cycle: occ=0 and inflight=0. Any word arriving on fifo_rdata_i in the flush cycle is discarded.
- Words still in the FIFO are not touched.

Counter:
- words_out_o increments by 1 on every pop.
- Wraps from 2^CNT_WIDTH-1 to 0. No saturation.

Errors:
- protocol_err_o is set when fifo_rd_error_i=1 is seen on any edge. It is cleared only by reset.
- It is expected never to set, because rd_en_o is gated by empty.

Boundaries:
- fifo_empty_i rising in the same cycle as a would-be issue: no read is issued.
- m_ready_i=1 while m_valid_o=0: no effect.
- Reset mid-stream: all buffered and in-flight data is lost and outputs return to reset values immediately.

Test Plan:
1. FIFO preloaded with 0x11..0x18, m_ready_i=1 -> m_valid_o rises 2 cycles after the first rd_en_o. Stream 0x11..0x18 is delivered on 8 consecutive clocks. words_out_o=8. rd_en_o is never high while fifo_empty_i=1. protocol_err_o=0.
2. Preload 4 words, m_ready_i=0 -> exactly 2 rd_en_o pulses, occ=2, m_data_o holds the first word. Raise m_ready_i -> all 4 words arrive in order with no duplicates or drops.
3. Random m_ready_i (50%) over 200 words written concurrently at a 10/14 ns clock ratio -> output sequence equals input sequence. words_out_o=200. The invariant occ+inflight<=2 holds every cycle.
4. occ=2 with inflight=0, then flush_i for 1 cycle with m_ready_i=0 -> next cycle m_valid_o=0. Subsequent words come from the FIFO contents only. words_out_o is unchanged.
5. Preload words_out_o near wrap: stream 3 words through with the counter starting at 0xFFFE -> the counter reads 0xFFFF, 0x0000, 0x0001.
6. Assert rst_i asynchronously while occ=2 -> m_valid_o, rd_en_o and words_out_o go to 0 without waiting for a clock edge. After release, normal draining resumes.

Source files
------------

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side drain stage for the async FIFO, in the read clock domain.
// It turns the FIFO's rd_en/rdata/empty port, which has one cycle of read
// latency, into a valid/ready stream. A 2-entry buffer holds words returned
// during consumer stalls, so the stream runs at one word per clock with no
// bubbles. The block also provides a synchronous flush, a transfer counter
// and a sticky read-error flag.
module fifo_rd_stream_adapter #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fifo_empty_i,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    input  logic                 fifo_rd_error_i,
    output logic                 rd_en_o,
    output logic                 m_valid_o,
    output logic [WIDTH-1:0]     m_data_o,
    input  logic                 m_ready_i,
    input  logic                 flush_i,
    output logic [CNT_WIDTH-1:0] words_out_o,
    output logic                 protocol_err_o
);

    // Buffer occupancy. The encoding equals the number of held words.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e                 occ_q, occ_d;
    logic                 inflight_q, inflight_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     head_q, head_d;
    logic [WIDTH-1:0]     tail_q, tail_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                 pop;
    logic [2:0]           committed;

    assign m_valid_o      = valid_q;
    assign m_data_o       = head_q;
    assign words_out_o    = cnt_q;
    assign protocol_err_o = err_q;

    assign pop = valid_q & m_ready_i;

    // Buffer slots still claimed after this cycle's pop. This includes the
    // word already in flight from the FIFO. A pop needs occ >= 1, so the
    // subtraction cannot underflow.
    assign committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    // Issue a read only if the returning word is sure to find a free slot.
    // m_ready_i reaches rd_en_o through a combinational path through pop.
    assign rd_en_o = !rst_i && !flush_i && !fifo_empty_i && (committed < 3'd2);

    // Next-state logic for the buffer, the in-flight flag, the counter and the error flag.
    always_comb begin
        // NOTE: every _d is given its hold value first, so no branch can leave a signal unassigned and infer a latch.
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = rd_en_o;
        cnt_d      = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
        err_d      = err_q | fifo_rd_error_i;

        // The returning word (inflight_q) goes into the slot left free after any pop, which keeps the words in order.
        case (occ_q)
            EMPTY: begin
                if (inflight_q) begin
                    occ_d  = ONE;
                    head_d = fifo_rdata_i;
                end
            end
            ONE: begin
                if (inflight_q && !pop) begin
                    occ_d  = TWO;
                    tail_d = fifo_rdata_i;
                end else if (inflight_q && pop) begin
                    head_d = fifo_rdata_i;
                end else if (pop) begin
                    occ_d  = EMPTY;
                end
            end
            TWO: begin
                // The issue rule prevents a word from returning while both slots are full.
                if (pop) begin
                    occ_d  = ONE;
                    head_d = tail_q;
                end
            end
            default: occ_d = EMPTY;
        endcase

        // A flush drops the buffered words and any word arriving this cycle.
        // A pop in the same cycle still completes and is counted above.
        if (flush_i) begin
            occ_d = EMPTY;
        end

        valid_d = (occ_d != EMPTY);
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments make every flop sample values from before the edge, whatever order the statements are in.
        if (rst_i) begin
            occ_q      <= EMPTY;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            // NOTE: the buffer entries are reset on purpose, so m_data_o reads a known 0 during and after reset.
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Self-checking bench for fifo_rd_stream_adapter.
// A queue-based FIFO model with one cycle of read latency feeds the DUT.
// Each word read from the model is pushed into an expected queue. A monitor
// pops that queue on every stream transfer and empties it on flush or reset.
module tb_fifo_rd_stream_adapter;

    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 wclk = 1'b0;
    logic                 rst = 1'b1;
    logic                 fifo_empty;
    logic [WIDTH-1:0]     fifo_rdata = '0;
    logic                 fifo_rd_error = 1'b0;
    logic                 rd_en;
    logic                 m_valid;
    logic [WIDTH-1:0]     m_data;
    logic                 m_ready = 1'b0;
    logic                 flush = 1'b0;
    logic [CNT_WIDTH-1:0] words_out;
    logic                 protocol_err;

    int checks = 0;
    int failures = 0;

    // FIFO model: word storage and free-running pointers.
    logic [WIDTH-1:0] fifo_mem [0:1023];
    int               wr_ptr = 0;
    int               rd_ptr = 0;

    // Words read from the FIFO and not yet delivered, oldest first.
    logic [WIDTH-1:0] exp_q [$];

    int               rd_pulses = 0;
    logic             hold_pend = 1'b0;
    logic [WIDTH-1:0] hold_data = '0;

    int               first_rd, first_v, vcount, run, max_run, p0, n_wr;
    logic             wr_done;
    logic [CNT_WIDTH-1:0] wrap_exp [3];

    fifo_rd_stream_adapter #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .fifo_empty_i    (fifo_empty),
        .fifo_rdata_i    (fifo_rdata),
        .fifo_rd_error_i (fifo_rd_error),
        .rd_en_o         (rd_en),
        .m_valid_o       (m_valid),
        .m_data_o        (m_data),
        .m_ready_i       (m_ready),
        .flush_i         (flush),
        .words_out_o     (words_out),
        .protocol_err_o  (protocol_err)
    );

    // Read clock period is 20, write clock period is 28 (a 10:14 ratio).
    // Write edges fall on odd times, so they never coincide with a read edge.
    always #10 clk = ~clk;
    initial begin
        #3;
        forever #14 wclk = ~wclk;
    end

    always_comb fifo_empty = (wr_ptr == rd_ptr);

    // FIFO read port: data is registered one cycle after rd_en. When no read
    // is issued, the data bus carries junk.
    always @(posedge clk) begin
        if (rd_en) begin
            fifo_rdata <= fifo_mem[rd_ptr % 1024];
            exp_q.push_back(fifo_mem[rd_ptr % 1024]);
            rd_ptr <= rd_ptr + 1;
        end else begin
            fifo_rdata <= WIDTH'($urandom);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fifo_write(input logic [WIDTH-1:0] d);
        fifo_mem[wr_ptr % 1024] = d;
        wr_ptr++;
    endtask

    task automatic wait_drain(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #6;
            if (fifo_empty && exp_q.size() == 0 && !m_valid) done = 1'b1;
        end
        check(name, done, 1);
    endtask

    // Monitor: samples 2 time units before each rising edge.
    always begin
        @(negedge clk);
        #8;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (rd_en) begin
                rd_pulses++;
                check("rd_en_while_empty", fifo_empty, 0);
            end
            check("outstanding_le_2", exp_q.size() <= 2, 1);
            if (hold_pend) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, hold_data);
            end
            if (m_valid && m_ready) begin
                check("pop_has_expect", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("stream_data", m_data, exp_q.pop_front());
            end
            if (flush) exp_q.delete();
            hold_pend = m_valid && !m_ready && !flush;
            hold_data = m_data;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wrap_exp[0] = 16'hFFFF;
        wrap_exp[1] = 16'h0000;
        wrap_exp[2] = 16'h0001;

        // Reset state. The FIFO already holds data, so rd_en must be gated by reset.
        rst = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) fifo_write(8'h11 + 8'(i));
        @(negedge clk);
        #6;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_words_out", words_out, 0);
        check("rst_err", protocol_err, 0);

        // Test 1: latency and full-throughput streaming of 0x11..0x18.
        @(negedge clk);
        rst = 1'b0;
        first_rd = -1; first_v = -1; vcount = 0; run = 0; max_run = 0;
        for (int i = 0; i < 20; i++) begin
            #6;
            if (rd_en && first_rd < 0) first_rd = i;
            if (m_valid && first_v < 0) first_v = i;
            if (m_valid) begin
                vcount++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            @(negedge clk);
        end
        check("t1_latency", first_v - first_rd, 2);
        check("t1_valid_run", max_run, 8);
        check("t1_valid_total", vcount, 8);
        check("t1_words_out", words_out, 8);
        check("t1_err", protocol_err, 0);

        // Test 2: backpressure, so only two reads are issued and the head holds.
        m_ready = 1'b0;
        p0 = rd_pulses;
        for (int i = 0; i < 4; i++) fifo_write(8'h21 + 8'(i));
        repeat (6) @(negedge clk);
        #6;
        check("t2_rd_pulses", rd_pulses - p0, 2);
        check("t2_valid", m_valid, 1);
        check("t2_head", m_data, 8'h21);
        @(negedge clk);
        m_ready = 1'b1;
        wait_drain("t2_drain", 50);
        check("t2_words_out", words_out, 12);

        // Test 4a: flush with both slots full and no transfer.
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_write(8'h31 + 8'(i));
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #6;
        check("t4_valid_after_flush", m_valid, 0);
        check("t4_words_unchanged", words_out, 12);
        @(negedge clk);
        m_ready = 1'b1;
        wait_drain("t4_drain", 50);
        check("t4_words_out", words_out, 14);

        // Test 4b: flush in the same cycle as a transfer. The pop still counts and no read is issued.
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_write(8'h41 + 8'(i));
        repeat (5) @(negedge clk);
        flush = 1'b1;
        m_ready = 1'b1;
        #6;
        check("t4b_rd_en_in_flush", rd_en, 0);
        @(negedge clk);
        flush = 1'b0;
        m_ready = 1'b0;
        #6;
        check("t4b_valid_after_flush", m_valid, 0);
        check("t4b_words_out", words_out, 15);
        @(negedge clk);
        m_ready = 1'b1;
        wait_drain("t4b_drain", 50);
        check("t4b_words_final", words_out, 17);

        // Test 3: 200 random words written on the other clock, random ready.
        @(negedge clk);
        wr_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    @(posedge wclk);
                    fifo_write(8'($urandom));
                end
                wr_done = 1'b1;
            end
            begin
                while (!wr_done) begin
                    @(negedge clk);
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(negedge clk);
        m_ready = 1'b1;
        wait_drain("t3_drain", 400);
        check("t3_words_out", words_out, 217);

        // Test 6: asynchronous reset while both slots are full.
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_write(8'h51 + 8'(i));
        repeat (5) @(negedge clk);
        #4;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t6_async_valid", m_valid, 0);
        check("t6_async_rd_en", rd_en, 0);
        check("t6_async_words", words_out, 0);
        check("t6_async_data", m_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        wait_drain("t6_drain", 50);
        check("t6_words_out", words_out, 2);

        // Test 5: run the counter to 0xFFFE, then watch it wrap.
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        n_wr = 0;
        for (int i = 0; i < 70000 && n_wr < 65534; i++) begin
            if (wr_ptr - rd_ptr < 4) begin
                fifo_write(8'($urandom));
                n_wr++;
            end
            @(negedge clk);
        end
        check("t5_all_written", n_wr, 65534);
        wait_drain("t5_drain", 50);
        check("t5_cnt_fffe", words_out, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            fifo_write(8'($urandom));
            wait_drain("t5_wrap_drain", 20);
            check("t5_wrap", words_out, wrap_exp[k]);
        end
        check("t5_err_clear", protocol_err, 0);

        // Sticky error flag: it is set by one pulse and cleared only by reset.
        @(negedge clk);
        fifo_rd_error = 1'b1;
        @(negedge clk);
        fifo_rd_error = 1'b0;
        repeat (3) @(negedge clk);
        #6;
        check("err_sticky", protocol_err, 1);
        #2;
        rst = 1'b1;
        #1;
        check("err_reset", protocol_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
